// File: rtl/seg_scan_capture.sv
// Receive-side 7-segment capture: debounces the active-low segment/select buses and decodes
// each stable one-hot pattern back to BCD. Define SEG_CAP_HEX_EN to also accept A..F glyphs.
module seg_scan_capture #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     sel_in,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   digit_out,
  output logic [DIGITS-1:0]     valid_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic                  frame_done,
  output logic                  err_out
);

  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Decode result: {legal, blank, value[3:0]}
  function automatic logic [5:0] decode_glyph(input logic [6:0] pat);
    logic [5:0] r;
    r = 6'b000000;
    case (pat)
      7'h40: r = {2'b10, 4'd0};
      7'h79: r = {2'b10, 4'd1};
      7'h24: r = {2'b10, 4'd2};
      7'h30: r = {2'b10, 4'd3};
      7'h19: r = {2'b10, 4'd4};
      7'h12: r = {2'b10, 4'd5};
      7'h02: r = {2'b10, 4'd6};
      7'h78: r = {2'b10, 4'd7};
      7'h00: r = {2'b10, 4'd8};
      7'h10: r = {2'b10, 4'd9};
`ifdef SEG_CAP_HEX_EN
      7'h08: r = {2'b10, 4'd10};
      7'h03: r = {2'b10, 4'd11};
      7'h46: r = {2'b10, 4'd12};
      7'h21: r = {2'b10, 4'd13};
      7'h06: r = {2'b10, 4'd14};
      7'h0E: r = {2'b10, 4'd15};
`endif
      7'h7F: r = {2'b01, 4'd0};
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  logic [7:0]          smp_seg_q, smp_seg_d;
  logic [DIGITS-1:0]   smp_sel_q, smp_sel_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] digit_q, digit_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                frame_q, frame_d;
  logic                err_q, err_d;

  logic                same;
  logic                capture;
  logic [3:0]          zcnt;
  logic [IDXW-1:0]     idx;
  logic [DIGITS-1:0]   mask_nxt;
  logic [5:0]          dec;

  always_comb begin
    smp_seg_d = seg_in;
    smp_sel_d = sel_in;
    same      = ({sel_in, seg_in} == {smp_sel_q, smp_seg_q});
    cnt_d     = '0;
    if (same) cnt_d = (cnt_q != CNT_MAX) ? cnt_q + CW'(1) : cnt_q;
    // Fires once per stable window: only on the step into saturation.
    capture   = same && (cnt_q == CNT_LAST);

    zcnt = 4'd0;
    idx  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!smp_sel_q[i]) begin
        zcnt = zcnt + 4'd1;
        idx  = IDXW'(i);
      end
    end
    dec      = decode_glyph(smp_seg_q[6:0]);
    mask_nxt = mask_q | ~smp_sel_q;

    digit_d = digit_q;
    valid_d = valid_q;
    dp_d    = dp_q;
    mask_d  = mask_q;
    frame_d = 1'b0;
    err_d   = err_clr ? 1'b0 : err_q;

    if (capture) begin
      if (zcnt > 4'd1) begin
        err_d = 1'b1;
      end else if (zcnt == 4'd1) begin
        dp_d[idx] = ~smp_seg_q[7];
        if (dec[5]) begin
          digit_d[4*idx +: 4] = dec[3:0];
          valid_d[idx]        = 1'b1;
        end else if (dec[4]) begin
          digit_d[4*idx +: 4] = 4'd0;
          valid_d[idx]        = 1'b0;
        end else begin
          valid_d[idx] = 1'b0;
          err_d        = 1'b1;
        end
        if (&mask_nxt) begin
          frame_d = 1'b1;
          mask_d  = '0;
        end else begin
          mask_d = mask_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_seg_q <= 8'hFF;
      smp_sel_q <= '1;
      cnt_q     <= '0;
      digit_q   <= '0;
      valid_q   <= '0;
      dp_q      <= '0;
      mask_q    <= '0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      smp_seg_q <= smp_seg_d;
      smp_sel_q <= smp_sel_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      dp_q      <= dp_d;
      mask_q    <= mask_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
    end
  end

  assign digit_out  = digit_q;
  assign valid_out  = valid_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_q;
  assign err_out    = err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus random scan traffic against a
// history-based reference model (capture = input run of exactly STABLE_CYCLES+1 edges).
module tb_seg_scan_capture;

  localparam int DIGITS = 8;
  localparam int SC     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [7:0]  sel_in;
  logic        err_clr;
  logic [31:0] digit_out;
  logic [7:0]  valid_out;
  logic [7:0]  dp_out;
  logic        frame_done;
  logic        err_out;

  seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .sel_in(sel_in), .err_clr(err_clr),
    .digit_out(digit_out), .valid_out(valid_out), .dp_out(dp_out),
    .frame_done(frame_done), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [6:0]  glyph [16];
`ifdef SEG_CAP_HEX_EN
  localparam int NLEG = 16;
`else
  localparam int NLEG = 10;
`endif
  logic [15:0] hist [$];
  logic [3:0]  m_dig [8];
  logic [7:0]  m_valid, m_dp, m_mask;
  logic        m_frame, m_err;
  int          frames_seen;

  function automatic logic [31:0] pack_digits();
    logic [31:0] p;
    for (int i = 0; i < 8; i++) p[4*i +: 4] = m_dig[i];
    return p;
  endfunction

  task automatic model_capture(input logic [7:0] s, input logic [7:0] d, output logic newerr);
    int zeros, ix, v;
    newerr = 1'b0;
    zeros = 0; ix = 0;
    for (int i = 0; i < 8; i++) if (!d[i]) begin zeros++; ix = i; end
    if (zeros > 1) newerr = 1'b1;
    else if (zeros == 1) begin
      m_dp[ix] = ~s[7];
      v = -1;
      for (int k = 0; k < NLEG; k++) if (glyph[k] == s[6:0]) v = k;
      if (v >= 0) begin m_dig[ix] = 4'(v); m_valid[ix] = 1'b1; end
      else if (s[6:0] == 7'h7F) begin m_dig[ix] = 4'd0; m_valid[ix] = 1'b0; end
      else begin m_valid[ix] = 1'b0; newerr = 1'b1; end
      m_mask[ix] = 1'b1;
      if (m_mask == 8'hFF) begin m_frame = 1'b1; m_mask = 8'h00; end
    end
  endtask

  task automatic model_edge(input logic [7:0] s, input logic [7:0] d, input logic c, input logic r);
    int run;
    logic newerr;
    m_frame = 1'b0;
    if (r) begin
      hist.delete();
      hist.push_back(16'hFFFF);
      for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;
      m_valid = 0; m_dp = 0; m_mask = 0; m_err = 0;
      return;
    end
    hist.push_back({d, s});
    if (hist.size() > SC + 2) void'(hist.pop_front());
    run = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k] != hist[hist.size() - 1]) break;
      run++;
    end
    newerr = 1'b0;
    if (run == SC + 1) model_capture(s, d, newerr);
    if (c) m_err = 1'b0;
    if (newerr) m_err = 1'b1;
  endtask

  task automatic compare_all();
    chk_val("digit_out", digit_out, pack_digits());
    chk_val("valid_out", {24'd0, valid_out}, {24'd0, m_valid});
    chk_val("dp_out", {24'd0, dp_out}, {24'd0, m_dp});
    chk_val("frame_done", {31'd0, frame_done}, {31'd0, m_frame});
    chk_val("err_out", {31'd0, err_out}, {31'd0, m_err});
    if (frame_done) frames_seen++;
  endtask

  task automatic step(input logic [7:0] s, input logic [7:0] d, input logic c, input logic r);
    @(negedge clk);
    seg_in = s; sel_in = d; err_clr = c; rst = r;
    @(posedge clk);
    model_edge(s, d, c, r);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [7:0] s, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) step(s, d, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] s, d, digit2_before;
    int n, r;
    glyph[0] = 7'h40; glyph[1] = 7'h79; glyph[2] = 7'h24; glyph[3] = 7'h30;
    glyph[4] = 7'h19; glyph[5] = 7'h12; glyph[6] = 7'h02; glyph[7] = 7'h78;
    glyph[8] = 7'h00; glyph[9] = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
    glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
    frames_seen = 0;
    rst = 1'b1; seg_in = 8'hFF; sel_in = 8'hFF; err_clr = 1'b0;

    step(8'hFF, 8'hFF, 1'b0, 1'b1);
    step(8'hFF, 8'hFF, 1'b0, 1'b1);
    chk_val("reset_digits", digit_out, 32'h0);
    chk_val("reset_err", {31'd0, err_out}, 32'h0);

    // Digit 1 shows 0 (dp off)
    hold(8'hC0, 8'hFD, 4);
    chk_val("t1_before5", {24'd0, valid_out}, 32'h0);
    hold(8'hC0, 8'hFD, 1);
    chk_val("t1_valid", {24'd0, valid_out}, 32'h02);
    chk_val("t1_dig1", {28'd0, digit_out[7:4]}, 32'h0);
    chk_val("t1_dp", {24'd0, dp_out}, 32'h0);
    hold(8'hC0, 8'hFD, 4);

    // Short glitch of 1 must not capture
    hold(8'h79, 8'hFE, 3);
    hold(8'hA4, 8'hFE, 5);
    chk_val("t2_dig0", {28'd0, digit_out[3:0]}, 32'h2);
    chk_val("t2_valid0", {31'd0, valid_out[0]}, 32'h1);

    // Multiplexed scan 0..7
    frames_seen = 0;
    for (int i = 0; i < 8; i++) begin
      s = {1'b1, glyph[i]};
      d = ~(8'h01 << i);
      hold(s, d, 6);
      hold(8'hFF, 8'hFF, 2);
    end
    chk_val("scan_frames", frames_seen, 1);
    chk_val("scan_digits", digit_out, 32'h76543210);
    chk_val("scan_valid", {24'd0, valid_out}, 32'hFF);

    // Hex glyph A on digit 2
    digit2_before = {4'd0, digit_out[11:8]};
    hold(8'h08, 8'hFB, 5);
`ifdef SEG_CAP_HEX_EN
    chk_val("hex_dig2", {28'd0, digit_out[11:8]}, 32'hA);
    chk_val("hex_valid2", {31'd0, valid_out[2]}, 32'h1);
    chk_val("hex_err", {31'd0, err_out}, 32'h0);
`else
    chk_val("hex_dig2", {28'd0, digit_out[11:8]}, {24'd0, digit2_before});
    chk_val("hex_valid2", {31'd0, valid_out[2]}, 32'h0);
    chk_val("hex_err", {31'd0, err_out}, 32'h1);
`endif

    // Multi-select error, clear, then clear racing a new error
    step(8'hFF, 8'hFF, 1'b1, 1'b0);
    hold(8'hFF, 8'hFF, 2);
    hold(8'h40, 8'hFC, 5);
    chk_val("multi_err", {31'd0, err_out}, 32'h1);
    step(8'h40, 8'hFC, 1'b1, 1'b0);
    chk_val("err_clr", {31'd0, err_out}, 32'h0);
    hold(8'h7E, 8'hFE, 4);
    step(8'h7E, 8'hFE, 1'b1, 1'b0);
    chk_val("set_wins", {31'd0, err_out}, 32'h1);

    // Reset mid-window
    hold(8'hFF, 8'hFF, 2);
    hold(8'hB0, 8'hF7, 3);
    step(8'hB0, 8'hF7, 1'b0, 1'b1);
    hold(8'hB0, 8'hF7, 2);
    chk_val("rst_win_digits", digit_out, 32'h0);
    chk_val("rst_win_valid", {24'd0, valid_out}, 32'h0);
    hold(8'hB0, 8'hF7, 3);
    chk_val("rst_fresh_dig3", {28'd0, digit_out[15:12]}, 32'h3);

    // Random scan traffic
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 5 || r == 9) s = {1'($urandom_range(0, 1)), glyph[$urandom_range(0, 9)]};
      else if (r == 6) s = {1'($urandom_range(0, 1)), glyph[$urandom_range(10, 15)]};
      else if (r == 7) s = {1'($urandom_range(0, 1)), 7'h7F};
      else s = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 6 || r == 9) d = ~(8'h01 << $urandom_range(0, 7));
      else if (r == 7) d = 8'hFF;
      else d = 8'($urandom);
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++)
        step(s, d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
